// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
// Optional hold-limit logic is enabled with macro ARB_TIMEOUT_EN.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned PRIO_FIXED  = 0;
  localparam int unsigned PRIO_RR     = 1;
  localparam int unsigned MAX_MASTERS = 32;

  function automatic logic [MAX_MASTERS-1:0] onehot(input int unsigned idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

  // Lowest set bit position; 0 when the vector is empty.
  function automatic int unsigned index_of(input logic [MAX_MASTERS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = MAX_MASTERS; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr_picker.sv
// Combinational winner selection: rotate requests by the pointer, priority
// encode, rotate the index back. Fixed mode uses a pointer of zero.
module arbiter_rr_picker
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDW         = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDW-1:0]         ptr,
  input  logic                   mode,
  output logic                   valid,
  output logic [IDW-1:0]         win
);

  int unsigned            base;
  int unsigned            k;
  logic [MAX_MASTERS-1:0] rot;
  logic [IDW-1:0]         src;

  always_comb begin
    base = 0;
    if (mode && (32'(ptr) < NUM_MASTERS)) base = 32'(ptr);
    rot = '0;
    src = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      src    = IDW'((i + base) % NUM_MASTERS);
      rot[i] = req[src];
    end
    valid = |req;
    k     = index_of(rot);
    win   = IDW'((k + base) % NUM_MASTERS);
  end

endmodule

// File: rtl/arbiter_nmaster.sv
// N-master bus arbiter with registered one-hot grants, fixed or round-robin.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive grant cycles.
module arbiter_nmaster
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned PRIORITY_MODE = 1,
  parameter int unsigned MAX_HOLD      = 16,
  localparam int unsigned IDW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [IDW-1:0]         grant_id,
  output logic                   bus_busy,
  output logic                   timeout
);

  localparam logic MODE_RR = (PRIORITY_MODE == PRIO_RR);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || MAX_HOLD < 2) begin : g_bad_params
    $error("arbiter_nmaster: unsupported parameter values");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] pick_req;
  logic                   pick_valid;
  logic [IDW-1:0]         pick_win;
  logic [MAX_MASTERS-1:0] win_oh;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD);
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   timeout_q, timeout_d;

  // A mask that would block every requester is ignored so a sole requester is regranted.
  always_comb begin
    pick_req = breq & ~mask_q;
    if (pick_req == '0) pick_req = breq;
  end
`else
  always_comb pick_req = breq;
`endif

  arbiter_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDW         (IDW)
  ) u_picker (
    .req   (pick_req),
    .ptr   (ptr_q),
    .mode  (MODE_RR),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_comb begin
    state_d    = state_q;
    bgrant_d   = bgrant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    win_oh     = onehot(32'(pick_win));
`ifdef ARB_TIMEOUT_EN
    hold_d     = hold_q;
    mask_d     = mask_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          bgrant_d   = win_oh[NUM_MASTERS-1:0];
          grant_id_d = pick_win;
          if (MODE_RR) ptr_d = IDW'((32'(pick_win) + 32'd1) % NUM_MASTERS);
`ifdef ARB_TIMEOUT_EN
          hold_d = '0;
          mask_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!breq[grant_id_q]) begin
          state_d  = IDLE;
          bgrant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          bgrant_d  = '0;
          timeout_d = 1'b1;
          mask_d    = bgrant_q;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        bgrant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bgrant_q   <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      bgrant_q   <= bgrant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign bgrant   = bgrant_q;
  assign grant_id = grant_id_q;
  assign bus_busy = (state_q == GRANT);

endmodule
